rr_bus_arbiter: RTL and testbench
=================================

Name: rr_bus_arbiter

Overview:
- Parametrised successor to the fixed 2-master, externally-granted slave mux.
- Connects N_MASTERS request/ack bus masters to one slave port.
- Performs its own round-robin arbitration and locks the grant for a whole transaction (request to ack).
- All slave-side outputs and master-side responses are registered; the slave sees one stable master per transaction.

Parameters:
- N_MASTERS, 4, number of master ports (2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, write/read data width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset: synchronous, active-high.
- m_req  in  N_MASTERS  per-master request; held high until that master's m_ack.
- m_cmd  in  N_MASTERS  per-master command, 1 = write, 0 = read.
- m_addr  in  N_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  N_MASTERS*DATA_W  packed write data, same packing.
- m_ack  out  N_MASTERS  one-cycle completion pulse to the granted master.
- m_rdata  out  N_MASTERS*DATA_W  read data; valid only with that master's m_ack, else 0.
- s_req  out  1  slave request.
- s_cmd  out  1  slave command.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_ack  in  1  slave completion, single-cycle pulse.
- s_rdata  in  DATA_W  slave read data, valid with s_ack.
- grant  out  N_MASTERS  one-hot current owner; all-zero when idle.

Behaviour:
- Reset: all outputs 0.
  - State IDLE; priority pointer = master 0 highest.
  - Applies mid-transaction: the in-flight transfer is abandoned and no m_ack is issued.
  - A later s_ack with state IDLE is ignored.
- FSM states IDLE, BUSY, RESP.
- IDLE with any m_req set:
  - Pick the winner: first requester searching from ptr upward, wrapping modulo N_MASTERS.
  - Next edge: grant = onehot(winner); s_req = 1; s_cmd/s_addr/s_wdata captured from the winner; go BUSY.
  - Latency: m_req at edge k gives s_req high after edge k+1.
- IDLE with no request: outputs stay 0, state stays IDLE.
- BUSY:
  - s_req and captured s_cmd/s_addr/s_wdata are held constant; changes on master inputs are ignored.
  - On s_ack = 1: next edge s_req = 0; m_ack[winner] = 1; m_rdata[winner] = s_rdata (writes too); ptr = winner+1 mod N_MASTERS; go RESP.
  - No timeout: BUSY waits indefinitely.
- RESP, exactly one cycle:
  - m_ack pulse visible; no arbitration, since the acked master's m_req is still high this cycle.
  - Next edge: m_ack = 0, m_rdata = 0, grant = 0; go IDLE.
- Throughput: back-to-back minimum 3 cycles per transaction when s_ack arrives the cycle after s_req.
- Fairness: the most recent winner has lowest priority next round. With all requesting continuously, order is 0,1,2,3,0,...
- Simultaneous requests in IDLE: resolved solely by ptr, with no fixed priority.
- s_ack while in IDLE or RESP: ignored.
- m_req dropped by the granted master during BUSY: transaction still completes and m_ack is still pulsed (protocol violation, tolerated).
- Non-granted m_ack bits are always 0; non-granted m_rdata slices are always 0.
- N_MASTERS = 1: degenerates to a registered pass-through with the same latency.

Decomposition:
- Package rr_bus_pkg:
  - State enum: IDLE, BUSY, RESP.
  - Localparam command encodings: CMD_READ = 0, CMD_WRITE = 1.
  - Function for the wrap-around priority search returning the winner index.
- Sub-module rr_pick:
  - Purely combinational; inputs req vector and ptr; outputs valid and winner index.
  - Reusable by other arbiters.
- FSM, capture registers and response registers live in rr_bus_arbiter.

Test Plan:
- Reset, then m_req = 0100, m_cmd[2] = 1, m_addr[2] = 0x1000, m_wdata[2] = 0xCAFE0001:
  - s_req rises one cycle later with s_addr = 0x1000, s_wdata = 0xCAFE0001, s_cmd = 1, grant = 0100.
  - s_ack after 2 cycles → m_ack[2] one-cycle pulse; s_req drops.
- Read: m_req = 0001, s_rdata = 0xDEADBEEF with s_ack → m_rdata[0] = 0xDEADBEEF only during m_ack[0]; all other slices 0.
- All four request continuously, slave acks the cycle after s_req:
  - Grant sequence 0001, 0010, 0100, 1000, 0001.
  - 3 cycles per transaction.
- Master 1 changes m_addr from 0x10 to 0x20 during BUSY → s_addr stays 0x10 until s_ack.
- Assert rst during BUSY with m_req = 0010:
  - All outputs 0 next cycle; no m_ack.
  - Stray s_ack afterwards is ignored.
  - Next arbitration starts from master 0 priority.
- m_req = 1001 after master 0 was last winner → master 3 granted first, then master 0.

Source files
------------

// File: rtl/rr_bus_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Holds the FSM state encoding, command codes and the wrap-around search.
package rr_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Widest arbiter the search helper supports.
    localparam int MAX_M = 16;

    // First set bit of req at or after ptr, wrapping modulo n.
    // Both ptr and the loop offset are below n, so one subtraction wraps.
    function automatic logic [3:0] rr_search(
        input logic [MAX_M-1:0] req,
        input logic [3:0]       ptr,
        input logic [4:0]       n
    );
        logic [3:0] w;
        logic       found;
        logic [4:0] idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_M; i++) begin
            idx = 5'(ptr) + 5'(i);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (5'(i) < n) && req[idx[3:0]]) begin
                w     = idx[3:0];
                found = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_pick.sv
// Combinational round-robin picker.
// Finds the first requester at or after ptr, wrapping around.
module rr_pick
    import rr_bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] winner
);

    logic [MAX_M-1:0] req_pad;
    logic [3:0]       ptr_pad;
    logic [3:0]       win_pad;

    // Widen to the helper's fixed width and run the wrap-around search.
    always_comb begin
        req_pad = '0;
        req_pad[N-1:0] = req;
        ptr_pad = '0;
        ptr_pad[IW-1:0] = ptr;
        win_pad = rr_search(req_pad, ptr_pad, 5'(N));
        valid   = |req;
        winner  = win_pad[IW-1:0];
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// N-master to one-slave bus arbiter with round-robin grant.
// The grant is locked from capture until the slave acks the transfer.
module rr_bus_arbiter
    import rr_bus_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS-1:0]        m_req,
    input  logic [N_MASTERS-1:0]        m_cmd,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
    output logic [N_MASTERS-1:0]        m_ack,
    output logic [N_MASTERS*DATA_W-1:0] m_rdata,
    output logic                        s_req,
    output logic                        s_cmd,
    output logic [ADDR_W-1:0]           s_addr,
    output logic [DATA_W-1:0]           s_wdata,
    input  logic                        s_ack,
    input  logic [DATA_W-1:0]           s_rdata,
    output logic [N_MASTERS-1:0]        grant
);

    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_MASTERS - 1);

    state_e                      state_q, state_d;
    logic [IW-1:0]               ptr_q, ptr_d;
    logic [IW-1:0]               win_q, win_d;
    logic [N_MASTERS-1:0]        grant_q, grant_d;
    logic                        s_req_q, s_req_d;
    logic                        s_cmd_q, s_cmd_d;
    logic [ADDR_W-1:0]           s_addr_q, s_addr_d;
    logic [DATA_W-1:0]           s_wdata_q, s_wdata_d;
    logic [N_MASTERS-1:0]        m_ack_q, m_ack_d;
    logic [N_MASTERS*DATA_W-1:0] m_rdata_q, m_rdata_d;

    logic          pick_valid;
    logic [IW-1:0] pick_win;

    rr_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .req    (m_req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_win)
    );

    // Next-state: arbitrate in IDLE, hold in BUSY, pulse ack in RESP.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        grant_d   = grant_q;
        s_req_d   = s_req_q;
        s_cmd_d   = s_cmd_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_ack_d   = '0;
        m_rdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d            = pick_win;
                    grant_d          = '0;
                    grant_d[pick_win] = 1'b1;
                    s_req_d          = 1'b1;
                    s_cmd_d          = m_cmd[pick_win];
                    s_addr_d  = m_addr[pick_win*ADDR_W +: ADDR_W];
                    s_wdata_d = m_wdata[pick_win*DATA_W +: DATA_W];
                    state_d          = BUSY;
                end
            end
            BUSY: begin
                if (s_ack) begin
                    s_req_d        = 1'b0;
                    s_cmd_d        = 1'b0;
                    s_addr_d       = '0;
                    s_wdata_d      = '0;
                    m_ack_d[win_q] = 1'b1;
                    m_rdata_d[win_q*DATA_W +: DATA_W] = s_rdata;
                    ptr_d   = (win_q == LAST) ? '0 : win_q + 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            grant_q   <= '0;
            s_req_q   <= 1'b0;
            s_cmd_q   <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_ack_q   <= '0;
            m_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            grant_q   <= grant_d;
            s_req_q   <= s_req_d;
            s_cmd_q   <= s_cmd_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_ack_q   <= m_ack_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    assign grant   = grant_q;
    assign s_req   = s_req_q;
    assign s_cmd   = s_cmd_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign m_ack   = m_ack_q;
    assign m_rdata = m_rdata_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed testbench for rr_bus_arbiter.
// Expected transfers are queued on drive and popped when s_req rises.
module tb_rr_bus_arbiter;
    import rr_bus_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic [N-1:0]  grant;
        logic          cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req;
    logic [N-1:0]    m_cmd;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_ack;
    logic [N*DW-1:0] m_rdata;
    logic            s_req;
    logic            s_cmd;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_ack;
    logic [DW-1:0]   s_rdata;
    logic [N-1:0]    grant;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    rr_bus_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_cmd   (m_cmd),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .s_req   (s_req),
        .s_cmd   (s_cmd),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_ack   (s_ack),
        .s_rdata (s_rdata),
        .grant   (grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic cmd,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        m_cmd[i]             = cmd;
        m_addr[i*AW +: AW]   = a;
        m_wdata[i*DW +: DW]  = d;
    endtask

    task automatic push(input logic [N-1:0] g, input int i);
        exp_t e;
        e.grant = g;
        e.cmd   = m_cmd[i];
        e.addr  = m_addr[i*AW +: AW];
        e.wdata = m_wdata[i*DW +: DW];
        exp_q.push_back(e);
    endtask

    task automatic run_txn(input int dly,
                           input logic [DW-1:0] rd,
                           input logic [N-1:0] req_after,
                           output int t_seen);
        exp_t            e;
        logic [N*DW-1:0] erd;
        int              k;
        k = 0;
        while (!s_req && k < 20) begin
            step();
            k++;
        end
        chk("s_req_rise", 128'(s_req), 128'(1));
        t_seen = cyc;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("grant", 128'(grant), 128'(e.grant));
        chk("s_cmd", 128'(s_cmd), 128'(e.cmd));
        chk("s_addr", 128'(s_addr), 128'(e.addr));
        chk("s_wdata", 128'(s_wdata), 128'(e.wdata));
        repeat (dly) begin
            step();
            chk("s_req_hold", 128'(s_req), 128'(1));
            chk("s_addr_hold", 128'(s_addr), 128'(e.addr));
        end
        s_ack   = 1'b1;
        s_rdata = rd;
        step();
        s_ack   = 1'b0;
        s_rdata = '0;
        m_req   = req_after;
        erd = '0;
        for (int i = 0; i < N; i++)
            if (e.grant[i]) erd[i*DW +: DW] = rd;
        chk("m_ack_pulse", 128'(m_ack), 128'(e.grant));
        chk("s_req_drop", 128'(s_req), 128'(0));
        chk("m_rdata", 128'(m_rdata), 128'(erd));
        step();
        chk("m_ack_end", 128'(m_ack), 128'(0));
        chk("grant_end", 128'(grant), 128'(0));
        chk("m_rdata_end", 128'(m_rdata), 128'(0));
    endtask

    initial begin
        int ts;
        int prev;
        rst     = 1'b1;
        m_req   = '0;
        m_cmd   = '0;
        m_addr  = '0;
        m_wdata = '0;
        s_ack   = 1'b0;
        s_rdata = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_s_req", 128'(s_req), 128'(0));
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_m_ack", 128'(m_ack), 128'(0));
        chk("rst_s_addr", 128'(s_addr), 128'(0));
        chk("rst_m_rdata", 128'(m_rdata), 128'(0));

        // Write from master 2, acked two cycles in.
        set_m(2, CMD_WRITE, 32'h1000, 32'hCAFE0001);
        m_req = 4'b0100;
        push(4'b0100, 2);
        step();
        chk("latency", 128'(s_req), 128'(1));
        run_txn(2, 32'h0, 4'b0000, ts);

        // Read by master 0.
        set_m(0, CMD_READ, 32'h0040, 32'h0);
        m_req = 4'b0001;
        push(4'b0001, 0);
        run_txn(0, 32'hDEADBEEF, 4'b0000, ts);

        // Master 1 changes address while BUSY.
        set_m(1, CMD_READ, 32'h10, 32'h5);
        m_req = 4'b0010;
        push(4'b0010, 1);
        step();
        m_addr[1*AW +: AW] = 32'h20;
        run_txn(2, 32'h1111, 4'b0000, ts);

        // Reset in the middle of a transfer.
        m_req = 4'b0010;
        step();
        chk("pre_rst_grant", 128'(grant), 128'(4'b0010));
        rst   = 1'b1;
        m_req = '0;
        step();
        rst = 1'b0;
        chk("mid_rst_s_req", 128'(s_req), 128'(0));
        chk("mid_rst_grant", 128'(grant), 128'(0));
        chk("mid_rst_m_ack", 128'(m_ack), 128'(0));
        s_ack   = 1'b1;
        s_rdata = 32'h77;
        step();
        s_ack   = 1'b0;
        s_rdata = '0;
        chk("stray_m_ack", 128'(m_ack), 128'(0));
        chk("stray_s_req", 128'(s_req), 128'(0));
        chk("stray_m_rdata", 128'(m_rdata), 128'(0));

        // All four request continuously.
        for (int i = 0; i < N; i++)
            set_m(i, 1'(i), 32'(32'h100 * i), 32'(32'hA0 + i));
        push(4'b0001, 0);
        push(4'b0010, 1);
        push(4'b0100, 2);
        push(4'b1000, 3);
        push(4'b0001, 0);
        m_req = 4'b1111;
        prev  = 0;
        for (int t = 0; t < 5; t++) begin
            run_txn(0, 32'(32'h200 + t),
                    (t == 4) ? 4'b0000 : 4'b1111, ts);
            if (t > 0) chk("throughput", 128'(ts - prev), 128'(3));
            prev = ts;
        end

        // Master 0 was last winner: 3 before 0.
        push(4'b1000, 3);
        push(4'b0001, 0);
        m_req = 4'b1001;
        run_txn(0, 32'h33, 4'b0001, ts);
        run_txn(0, 32'h44, 4'b0000, ts);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
